// File: rtl/menu_selector.sv
// Menu navigation with keyboard edge detection and auto-repeat, plus a
// frame-synchronised pointer overlay composited onto the menu video stream.
module menu_selector #(
    parameter int          N_ITEMS    = 4,
    parameter bit          WRAP       = 1'b1,
    parameter int          PTR_X      = 100,
    parameter int          PTR_Y0     = 200,
    parameter int          PTR_STEP   = 60,
    parameter int          PTR_W      = 20,
    parameter int          PTR_H      = 20,
    parameter logic [11:0] PTR_RGB    = 12'hF00,
    parameter logic [31:0] REP_DELAY  = 32'd20_000_000,
    parameter logic [31:0] REP_PERIOD = 32'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [2:0]  keyboard_in,
    input  logic        back_to_main_menu_flag,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [3:0]  sel_index,
    output logic        start_game_flag,
    output logic [3:0]  start_item
);

    typedef enum logic [1:0] {
        ST_MENU   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_GAME   = 2'd2
    } state_t;

    localparam logic [3:0]  LAST_IDX   = 4'(N_ITEMS - 1);
    localparam logic [10:0] PX_LO      = 11'(PTR_X);
    localparam logic [10:0] PX_HI      = 11'(PTR_X + PTR_W);
    localparam logic [10:0] PY0        = 11'(PTR_Y0);
    localparam logic [10:0] PSTEP      = 11'(PTR_STEP);
    localparam logic [10:0] PH         = 11'(PTR_H);
    localparam logic [31:0] REP_LIMIT  = REP_DELAY + REP_PERIOD;
    localparam logic [31:0] REP_RELOAD = REP_DELAY + 32'd1;

    function automatic logic [3:0] next_index(input logic [3:0] idx, input logic go_up);
        logic [3:0] res;
        res = idx;
        if (go_up) begin
            if (idx == 4'd0) res = WRAP ? LAST_IDX : 4'd0;
            else             res = idx - 4'd1;
        end else begin
            if (idx >= LAST_IDX) res = WRAP ? 4'd0 : LAST_IDX;
            else                 res = idx + 4'd1;
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  key_q, key_prev_q;
    logic        key_init_q;
    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic        start_flag_q, start_flag_d;
    logic [3:0]  start_item_q, start_item_d;
    logic [10:0] ptr_y_q, ptr_y_d;
    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] rgb_q, rgb_d;

    logic [2:0]  edge_s;
    logic        menu_s, enter_s, one_up_s, one_dn_s, dir_edge_s, rep_fire_s, step_s;
    logic        in_box_s, vs_rise_s;
    logic [10:0] ptr_y_next_s;

    assign edge_s     = key_q & ~key_prev_q;
    assign menu_s     = (state_q == ST_MENU);
    assign enter_s    = menu_s & edge_s[2];
    assign one_up_s   = key_q[0] & ~key_q[1];
    assign one_dn_s   = key_q[1] & ~key_q[0];
    assign dir_edge_s = (one_up_s | one_dn_s) & (edge_s[0] | edge_s[1]);
    assign rep_fire_s = (rep_cnt_q != 32'd0) &&
                        ((rep_cnt_q == REP_DELAY) || (rep_cnt_q == REP_LIMIT));
    assign step_s     = menu_s & ~enter_s & (one_up_s | one_dn_s) & (dir_edge_s | rep_fire_s);

    assign ptr_y_next_s = PY0 + 11'(sel_q) * PSTEP;
    assign vs_rise_s    = vsync_in & ~vsync_q;
    assign in_box_s     = (hcount_in >= PX_LO) && (hcount_in < PX_HI) &&
                          (vcount_in >= ptr_y_q) && (vcount_in < (ptr_y_q + PH));

    // Key history; the first cycle after reset seeds prev with the live level so a held key gives no edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q      <= 3'b000;
            key_prev_q <= 3'b000;
            key_init_q <= 1'b0;
        end else begin
            key_q      <= keyboard_in;
            key_prev_q <= key_init_q ? key_q : keyboard_in;
            key_init_q <= 1'b1;
        end
    end

    // Repeat counter: counts cycles since the press edge, reloads after each periodic repeat
    always_comb begin
        rep_cnt_d = 32'd0;
        if (menu_s && !enter_s && (one_up_s || one_dn_s)) begin
            if (dir_edge_s)                   rep_cnt_d = 32'd1;
            else if (rep_cnt_q == 32'd0)      rep_cnt_d = 32'd0;
            else if (rep_cnt_q == REP_LIMIT)  rep_cnt_d = REP_RELOAD;
            else                              rep_cnt_d = rep_cnt_q + 32'd1;
        end else begin
            rep_cnt_d = 32'd0;
        end
    end

    // Menu FSM next state, selection and confirm capture
    always_comb begin
        state_d      = state_q;
        start_flag_d = 1'b0;
        start_item_d = start_item_q;
        sel_d        = sel_q;
        if (step_s) sel_d = next_index(sel_q, one_up_s);
        else        sel_d = sel_q;
        case (state_q)
            ST_MENU: begin
                if (enter_s) begin
                    state_d      = ST_LAUNCH;
                    start_flag_d = 1'b1;
                    start_item_d = sel_q;
                end else begin
                    state_d = ST_MENU;
                end
            end
            ST_LAUNCH: state_d = ST_GAME;
            ST_GAME: begin
                if (back_to_main_menu_flag) state_d = ST_MENU;
                else                        state_d = ST_GAME;
            end
            default: state_d = ST_MENU;
        endcase
    end

    // Pointer row latched only at vsync rise; pixel compositing for the incoming pixel
    always_comb begin
        ptr_y_d = ptr_y_q;
        rgb_d   = rgb_in;
        if (vs_rise_s) ptr_y_d = ptr_y_next_s;
        else           ptr_y_d = ptr_y_q;
        if (hblnk_in || vblnk_in)                rgb_d = 12'h000;
        else if ((state_q != ST_GAME) && in_box_s) rgb_d = PTR_RGB;
        else                                     rgb_d = rgb_in;
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_MENU;
            rep_cnt_q    <= 32'd0;
            sel_q        <= 4'd0;
            start_flag_q <= 1'b0;
            start_item_q <= 4'd0;
            ptr_y_q      <= PY0;
        end else begin
            state_q      <= state_d;
            rep_cnt_q    <= rep_cnt_d;
            sel_q        <= sel_d;
            start_flag_q <= start_flag_d;
            start_item_q <= start_item_d;
            ptr_y_q      <= ptr_y_d;
        end
    end

    // One-stage video pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= 12'h000;
        end else begin
            hcount_q <= hcount_in;
            vcount_q <= vcount_in;
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
            hblnk_q  <= hblnk_in;
            vblnk_q  <= vblnk_in;
            rgb_q    <= rgb_d;
        end
    end

    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign hsync_out       = hsync_q;
    assign vsync_out       = vsync_q;
    assign hblnk_out       = hblnk_q;
    assign vblnk_out       = vblnk_q;
    assign rgb_out         = rgb_q;
    assign sel_index       = sel_q;
    assign start_game_flag = start_flag_q;
    assign start_item      = start_item_q;

endmodule

// File: tb/tb_menu_selector.sv
// Directed bench for menu_selector: a wrapping and a saturating instance share
// the same stimulus; expected values are hand-derived constants.
module tb_menu_selector;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [2:0]  kb;
    logic        back;

    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [3:0]  sel_index, start_item;
    logic        start_game_flag;

    logic [10:0] s_hcount, s_vcount;
    logic        s_hsync, s_vsync, s_hblnk, s_vblnk;
    logic [11:0] s_rgb;
    logic [3:0]  s_sel, s_item;
    logic        s_start;

    int n_total = 0;
    int n_bad   = 0;
    int rep_ticks[6] = '{2, 12, 16, 20, 24, 28};

    always #5 clk = ~clk;

    menu_selector #(.N_ITEMS(4), .WRAP(1'b1), .REP_DELAY(32'd10), .REP_PERIOD(32'd4)) u_dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .keyboard_in(kb), .back_to_main_menu_flag(back),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .sel_index(sel_index), .start_game_flag(start_game_flag),
        .start_item(start_item)
    );

    menu_selector #(.N_ITEMS(4), .WRAP(1'b0), .REP_DELAY(32'd10), .REP_PERIOD(32'd4)) u_dut_sat (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .keyboard_in(kb), .back_to_main_menu_flag(back),
        .hcount_out(s_hcount), .vcount_out(s_vcount),
        .hsync_out(s_hsync), .vsync_out(s_vsync), .hblnk_out(s_hblnk), .vblnk_out(s_vblnk),
        .rgb_out(s_rgb), .sel_index(s_sel), .start_game_flag(s_start),
        .start_item(s_item)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] k);
        kb = k;
        tick();
        kb = 3'b000;
        tick();
    endtask

    task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] bg,
                       input logic hb, input logic vb);
        hcount_in = h;
        vcount_in = v;
        rgb_in    = bg;
        hblnk_in  = hb;
        vblnk_in  = vb;
        tick();
    endtask

    task automatic sel_both(input string tag, input logic [3:0] w, input logic [3:0] s);
        check_eq({tag, "_wrap"}, 32'(sel_index), 32'(w));
        check_eq({tag, "_sat"},  32'(s_sel),     32'(s));
    endtask

    initial begin
        int steps;
        rst = 1'b0; kb = 3'b000; back = 1'b0;
        hcount_in = 11'd100; vcount_in = 11'd200; rgb_in = 12'hABC;
        hsync_in = 1'b1; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
        repeat (3) tick();
        check_eq("rst_sel",    32'(sel_index),       32'd0);
        check_eq("rst_flag",   32'(start_game_flag), 32'd0);
        check_eq("rst_item",   32'(start_item),      32'd0);
        check_eq("rst_rgb",    32'(rgb_out),         32'd0);
        check_eq("rst_hcount", 32'(hcount_out),      32'd0);
        check_eq("rst_hsync",  32'(hsync_out),       32'd0);
        rst = 1'b1;
        tick();
        check_eq("ptr_reset_row", 32'(rgb_out),    32'h00000F00);
        check_eq("hcount_dly",    32'(hcount_out), 32'd100);
        check_eq("hsync_dly",     32'(hsync_out),  32'd1);
        hcount_in = 11'd5;
        #1;
        check_eq("hcount_hold",   32'(hcount_out), 32'd100);
        tick();
        check_eq("hcount_next",   32'(hcount_out), 32'd5);
        check_eq("bg_pass",       32'(rgb_out),    32'h00000ABC);

        // selection 0 -> 1 mid-frame; pointer must not move before vsync rise
        kb = 3'b010;
        tick();
        check_eq("key_latency", 32'(sel_index), 32'd0);
        kb = 3'b000;
        tick();
        sel_both("down1", 4'd1, 4'd1);
        pix(11'd100, 11'd200, 12'h123, 1'b0, 1'b0);
        check_eq("old_ptr_kept", 32'(rgb_out), 32'h00000F00);
        pix(11'd100, 11'd260, 12'h123, 1'b0, 1'b0);
        check_eq("new_ptr_early", 32'(rgb_out), 32'h00000123);
        vsync_in = 1'b1;
        tick();
        check_eq("vsync_dly", 32'(vsync_out), 32'd1);
        vsync_in = 1'b0;
        tick();
        pix(11'd100, 11'd260, 12'h123, 1'b0, 1'b0); check_eq("ptr_tl",     32'(rgb_out), 32'h00000F00);
        pix(11'd119, 11'd279, 12'h123, 1'b0, 1'b0); check_eq("ptr_br",     32'(rgb_out), 32'h00000F00);
        pix(11'd120, 11'd260, 12'h123, 1'b0, 1'b0); check_eq("ptr_right",  32'(rgb_out), 32'h00000123);
        pix(11'd99,  11'd279, 12'h123, 1'b0, 1'b0); check_eq("ptr_left",   32'(rgb_out), 32'h00000123);
        pix(11'd100, 11'd280, 12'h123, 1'b0, 1'b0); check_eq("ptr_below",  32'(rgb_out), 32'h00000123);
        pix(11'd100, 11'd259, 12'h123, 1'b0, 1'b0); check_eq("ptr_above",  32'(rgb_out), 32'h00000123);
        pix(11'd100, 11'd200, 12'h123, 1'b0, 1'b0); check_eq("old_ptr_gone", 32'(rgb_out), 32'h00000123);
        pix(11'd110, 11'd270, 12'h123, 1'b1, 1'b0); check_eq("hblank_ptr", 32'(rgb_out), 32'd0);
        pix(11'd110, 11'd270, 12'h123, 1'b0, 1'b1); check_eq("vblank_ptr", 32'(rgb_out), 32'd0);
        hblnk_in = 1'b0; vblnk_in = 1'b0;

        // stepping, wrap versus saturate
        press(3'b010); sel_both("down2", 4'd2, 4'd2);
        press(3'b010); sel_both("down3", 4'd3, 4'd3);
        press(3'b010); sel_both("down_end", 4'd0, 4'd3);
        press(3'b001); sel_both("up_wrap", 4'd3, 4'd2);
        press(3'b001); sel_both("up2", 4'd2, 4'd1);
        press(3'b001); sel_both("up3", 4'd1, 4'd0);
        press(3'b001); sel_both("up_end", 4'd0, 4'd0);
        press(3'b011); sel_both("both_keys", 4'd0, 4'd0);

        // auto-repeat: hold down for 30 cycles
        kb = 3'b010;
        for (int i = 1; i <= 30; i++) begin
            tick();
            steps = 0;
            for (int j = 0; j < 6; j++) if (i >= rep_ticks[j]) steps++;
            check_eq($sformatf("rep_t%0d", i), 32'(sel_index), 32'(steps % 4));
        end
        check_eq("rep_sat", 32'(s_sel), 32'd3);
        kb = 3'b000;
        repeat (10) tick();
        sel_both("rep_release", 4'd2, 4'd3);

        // confirm from index 2, then keys ignored in GAME
        hcount_in = 11'd100; vcount_in = 11'd260; rgb_in = 12'h5A5;
        kb = 3'b100;
        tick();
        check_eq("enter_latency", 32'(start_game_flag), 32'd0);
        check_eq("menu_ptr",      32'(rgb_out),         32'h00000F00);
        kb = 3'b000;
        tick();
        check_eq("start_pulse",    32'(start_game_flag), 32'd1);
        check_eq("start_item",     32'(start_item),      32'd2);
        check_eq("start_item_sat", 32'(s_item),          32'd3);
        tick();
        check_eq("pulse_width",    32'(start_game_flag), 32'd0);
        tick();
        check_eq("game_rgb",       32'(rgb_out),         32'h000005A5);
        pix(11'd500, 11'd10, 12'h321, 1'b0, 1'b0);
        check_eq("game_rgb2",      32'(rgb_out),         32'h00000321);
        press(3'b010);
        press(3'b001);
        check_eq("game_keys_ign",  32'(sel_index),       32'd2);
        press(3'b100);
        check_eq("game_enter_ign", 32'(start_game_flag), 32'd0);
        back = 1'b1;
        tick();
        back = 1'b0;
        tick();
        check_eq("back_sel", 32'(sel_index), 32'd2);
        pix(11'd100, 11'd260, 12'h5A5, 1'b0, 1'b0);
        check_eq("back_menu_ptr", 32'(rgb_out), 32'h00000F00);

        // enter and down edges together: enter wins
        kb = 3'b110;
        tick();
        kb = 3'b000;
        tick();
        check_eq("enter_win_flag", 32'(start_game_flag), 32'd1);
        check_eq("enter_win_item", 32'(start_item),      32'd2);
        check_eq("enter_win_sel",  32'(sel_index),       32'd2);
        tick();
        back = 1'b1;
        tick();
        back = 1'b0;
        tick();

        // reset while a key is held: no step until re-pressed
        kb = 3'b010;
        tick();
        tick();
        check_eq("hold_step", 32'(sel_index), 32'd3);
        repeat (3) tick();
        rst = 1'b0;
        #2;
        check_eq("async_rst_sel", 32'(sel_index), 32'd0);
        tick();
        rst = 1'b1;
        repeat (15) tick();
        check_eq("rst_hold_nostep", 32'(sel_index), 32'd0);
        kb = 3'b000;
        tick();
        press(3'b010);
        sel_both("repress", 4'd1, 4'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/menu_selector.md
# menu_selector

Parametrised menu navigation and pointer-overlay block for the game menu path. It takes the VGA timing and background stream from the menu renderer, tracks the selected item from debounced keyboard levels with edge detection, auto-repeat and optional wrap-around, and draws a frame-synchronised pointer rectangle. On confirm it issues a start pulse tagged with the selected item, then locks navigation until the game returns to the menu.

## Interface
Parameters:
- N_ITEMS, 4: number of selectable items, 2..16.
- WRAP, 1: 1 = index wraps at the ends; 0 = index saturates.
- PTR_X, 100: pointer left edge, in pixels.
- PTR_Y0, 200: pointer top edge for item 0.
- PTR_STEP, 60: vertical pitch between items.
- PTR_W, 20: pointer width in pixels.
- PTR_H, 20: pointer height in pixels.
- PTR_RGB, 12'hF00: pointer colour.
- REP_DELAY, 32'd20_000_000: hold cycles before the first auto-repeat.
- REP_PERIOD, 32'd5_000_000: cycles between subsequent repeats.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- hcount_in, vcount_in  in  11  pixel position.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1  timing.
- rgb_in  in  12  background pixel.
- keyboard_in  in  3  level inputs: [0] up, [1] down, [2] enter; synchronous to clk.
- back_to_main_menu_flag  in  1  pulse or level; game finished.
- hcount_out, vcount_out  out  11  delayed timing.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed timing.
- rgb_out  out  12  composited pixel.
- sel_index  out  4  current selection.
- start_game_flag  out  1  one-cycle confirm pulse.
- start_item  out  4  item index captured at confirm.

## Operation
- FSM states: MENU, LAUNCH, GAME.
  - MENU: navigation active.
  - MENU→LAUNCH on the rising edge of enter.
  - LAUNCH lasts exactly one cycle: start_game_flag=1, start_item=sel_index.
  - LAUNCH→GAME unconditionally.
  - GAME→MENU when back_to_main_menu_flag=1. sel_index is preserved across the round trip.
- Key handling: each key is registered once. An edge is detected as cur & ~prev.
  - Enter is honoured only in MENU.
  - In GAME and LAUNCH, all keys are ignored, edge registers keep tracking, and the repeat counter is held at 0.
- Step rules:
  - Up decrements sel_index; down increments it.
  - At the ends: with WRAP=1, 0→N_ITEMS-1 on up and N_ITEMS-1→0 on down. With WRAP=0, the index saturates.
  - Up and down both asserted, or both edges in the same cycle: no step, and the repeat counter is cleared.
  - Enter edge in the same cycle as an up/down edge: enter wins and no step occurs. start_item is the pre-step index.
- Auto-repeat: while exactly one of up/down is held, a 32-bit counter runs from the press edge.
  - First repeat step at REP_DELAY cycles after the edge, then one step every REP_PERIOD cycles.
  - Release or a direction change clears the counter.
- Pointer position: ptr_y_next = PTR_Y0 + sel_index*PTR_STEP, computed in 11 bits with no overflow check (parameter choice guarantees fit).
  - The displayed pointer registers (ptr_y_q) load only on the rising edge of vsync_in. This keeps the pointer tear-free.
- Pixel compositing is one registered stage. For the input pixel:
  - Either blank asserted: rgb_out = 0.
  - Else if state≠GAME and PTR_X ≤ hcount < PTR_X+PTR_W and ptr_y_q ≤ vcount < ptr_y_q+PTR_H: rgb_out = PTR_RGB.
  - Else: rgb_out = rgb_in.

## Timing
- All timing outputs and rgb_out are delayed exactly 1 clk relative to their inputs.
- Key edge → sel_index update: 2 clk (sync register plus index register).
- Enter edge → start_game_flag: 2 clk. The pulse is exactly 1 clk wide.
- A sel_index change appears on screen from the first frame whose vsync rising edge follows the change.
- Reset values (asynchronous, rst=0):
  - State = MENU.
  - sel_index, start_item, start_game_flag = 0.
  - ptr_y_q = PTR_Y0.
  - All timing outputs and rgb_out = 0.
  - Key history = 0, repeat counter = 0.
- Reset asserted mid-hold: the counter clears. After release, a still-held key produces no step until it is released and pressed again, because prev is captured as the key is sampled.

## Test plan
- Reset, then pulse down three times with N_ITEMS=4, WRAP=1 → sel_index goes 1, 2, 3. A fourth down → 0. An up from 0 → 3.
- WRAP=0, sel_index=0: up → sel_index stays 0. At index 3, down → stays 3.
- REP_DELAY=10, REP_PERIOD=4: hold down for 30 cycles from index 0 → steps at edge+2, +12, +16, +20, +24, +28 (cycles measured from the sync'd edge).
- sel_index=2, press enter → start_game_flag high for exactly 1 clk, start_item=2. Further keys are ignored. Pulse back_to_main_menu_flag → state MENU, sel_index still 2.
- sel_index changes mid-frame from 0 to 1 → the pointer stays at rows 200..219 until the next vsync rising edge, then moves to rows 260..279 with rgb_out=12'hF00 at hcount 100..119.
- Blanking asserted inside the pointer area → rgb_out=0. In GAME state, rgb_out equals rgb_in delayed by 1 clk everywhere.
